// File: rtl/systolic_bridge_pkg.sv
// Shared FSM state type and default sizing for the systolic stream bridge.
package systolic_bridge_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_ROWS    = 4;
    localparam int DEF_COLS    = 4;
    localparam int DEF_K       = 4;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        SEND   = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_c_serializer.sv
// Holds one captured C matrix and drains it word by word over a valid/ready port.
module systolic_c_serializer #(
    parameter int ACC_W  = 32,
    parameter int NWORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [NWORDS*ACC_W-1:0]   c_in,
    input  logic                      m_ready,
    output logic                      m_valid,
    output logic [ACC_W-1:0]          m_data,
    output logic                      last_hs
);

    localparam int IW = $clog2(NWORDS + 1);
    localparam int SW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    logic [NWORDS-1:0][ACC_W-1:0] c_buf;
    logic [IW-1:0]                idx;
    logic                         active;

    // m_data is a mux off registered state, so it cannot move while stalled
    assign m_valid = active;
    assign m_data  = c_buf[idx[SW-1:0]];
    assign last_hs = active && m_ready && (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_buf  <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            c_buf  <= c_in;
            idx    <= '0;
            active <= 1'b1;
        end else if (active && m_ready) begin
            if (idx == LAST) begin
                idx    <= '0;
                active <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_stream_bridge.sv
// Loads A and B from a byte stream, kicks the systolic core, and streams C back out.
module systolic_stream_bridge
    import systolic_bridge_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int K       = DEF_K,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    input  logic [DATA_W-1:0]                  s_data,
    output logic                               s_ready,
    output logic                               m_valid,
    output logic [ACC_W-1:0]                   m_data,
    input  logic                               m_ready,
    output logic                               core_start,
    input  logic                               core_busy,
    input  logic                               core_done,
    output logic signed [ROWS*K*DATA_W-1:0]    a_flat,
    output logic signed [K*COLS*DATA_W-1:0]    b_flat,
    input  logic signed [ROWS*COLS*ACC_W-1:0]  c_flat,
    output logic                               bridge_busy,
    output logic                               timeout_err
);

    localparam int NA   = ROWS * K;
    localparam int NB   = K * COLS;
    localparam int NC   = ROWS * COLS;
    localparam int NMAX = (NA > NB) ? NA : NB;
    localparam int BW   = $clog2(NMAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int AIW  = $clog2(NA);
    localparam int BIW  = $clog2(NB);
    localparam logic [BW-1:0] A_LAST = BW'(NA - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t                   state, state_nxt;
    logic [BW-1:0]            byte_cnt;
    logic [TW-1:0]            wait_cnt;
    logic                     rdy_en;
    logic [NA-1:0][DATA_W-1:0] a_q;
    logic [NB-1:0][DATA_W-1:0] b_q;
    logic                     accept, c_load, send_last;

    // Core status is informational only; completion is signalled by core_done.
    logic unused_busy;
    assign unused_busy = core_busy;

    assign s_ready     = rdy_en && (state == LOAD_A || state == LOAD_B);
    assign accept      = s_valid && s_ready;
    assign c_load      = (state == WAIT) && core_done;
    assign core_start  = (state == START);
    assign bridge_busy = !(state == LOAD_A && byte_cnt == '0);
    assign a_flat      = a_q;
    assign b_flat      = b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD_A;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A: if (accept && byte_cnt == A_LAST) state_nxt = LOAD_B;
            LOAD_B: if (accept && byte_cnt == B_LAST) state_nxt = START;
            START:  state_nxt = WAIT;
            WAIT: begin
                if (core_done)               state_nxt = SEND;
                else if (wait_cnt == T_LAST) state_nxt = LOAD_A;
            end
            SEND:   if (send_last) state_nxt = LOAD_A;
            default: state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            if (state_nxt != state) byte_cnt <= '0;
            else if (accept)        byte_cnt <= byte_cnt + 1'b1;
            if (accept && state == LOAD_A) a_q[byte_cnt[AIW-1:0]] <= s_data;
            if (accept && state == LOAD_B) b_q[byte_cnt[BIW-1:0]] <= s_data;
            if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                                    wait_cnt <= '0;
            // Sticky until reset so software can see that a run was dropped
            if (state == WAIT && !core_done && wait_cnt == T_LAST) timeout_err <= 1'b1;
        end
    end

    systolic_c_serializer #(
        .ACC_W  (ACC_W),
        .NWORDS (NC)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (c_load),
        .c_in    (c_flat),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .last_hs (send_last)
    );

endmodule

// File: tb/tb_systolic_stream_bridge.sv
// Directed bench for the systolic stream bridge with a behavioural matrix core.
module tb_systolic_stream_bridge;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_ready;
    logic               m_valid;
    logic [31:0]        m_data;
    logic               m_ready;
    logic               core_start;
    logic               core_busy;
    logic               core_done;
    logic signed [127:0] a_flat;
    logic signed [127:0] b_flat;
    logic signed [511:0] c_flat;
    logic               bridge_busy;
    logic               timeout_err;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int start_cnt  = 0;
    int nhs;
    logic       core_en;
    logic       done_force;
    logic [2:0] lat;
    logic [7:0]  ma [16];
    logic [7:0]  mb [16];
    logic [31:0] got [16];

    always #5 clk = ~clk;

    systolic_stream_bridge #(
        .DATA_W(8), .ACC_W(32), .ROWS(4), .COLS(4), .K(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
        .bridge_busy(bridge_busy), .timeout_err(timeout_err)
    );

    // Behavioural core: C = A*B, done pulses three cycles after start.
    always_comb begin
        c_flat = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += $signed(a_flat[(r*4+k)*8 +: 8]) * $signed(b_flat[(k*4+c)*8 +: 8]);
                c_flat[(r*4+c)*32 +: 32] = acc;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    lat <= 3'd0;
        else if (core_start && core_en) lat <= 3'd3;
        else if (lat != 3'd0)          lat <= lat - 3'd1;
    end

    always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

    assign core_busy = (lat != 3'd0);
    assign core_done = (lat == 3'd1) || done_force;

    task automatic send_range(input bit is_b, input int lo, input int hi, input int gapmax);
        for (int i = lo; i < hi; i++) begin
            int gap, n;
            gap = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
            repeat (gap) begin @(negedge clk); s_valid = 1'b0; end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = is_b ? mb[i] : ma[i];
            n = 0;
            while (!s_ready && n < 50) begin @(negedge clk); n++; end
            assert_cnt++;
            if (s_ready !== 1'b1) begin
                fail_cnt++;
                $display("FAIL s_ready_wait byte %0d: s_ready=%b required 1", i, s_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect(input bit stall_mode);
        int cyc;
        logic prev_stall;
        logic [31:0] prev_data;
        nhs = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (nhs < 16 && cyc < 400) begin
            logic rdy;
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                assert_cnt++;
                if (m_data !== prev_data) begin
                    fail_cnt++;
                    $display("FAIL stall_stable: m_data=%h required %h", m_data, prev_data);
                end
            end
            rdy = stall_mode ? (cyc % 3 == 0) : 1'b1;
            m_ready = rdy;
            if (m_valid && rdy) begin got[nhs] = m_data; nhs++; end
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
        end
        @(negedge clk);
        m_ready = 1'b1;
        assert_cnt++;
        if (nhs !== 16) begin
            fail_cnt++;
            $display("FAIL handshake_count: got %0d required 16", nhs);
        end
        assert_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL post_send: m_valid=%b s_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    task automatic set_ab(input int a_mode, input int b_mode);
        for (int i = 0; i < 16; i++) begin
            case (a_mode)
                0: ma[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
                1: ma[i] = 8'hFF;
                2: ma[i] = (i / 4 == i % 4) ? 8'd2 : 8'd0;
                default: ma[i] = (i / 4 == i % 4) ? 8'hFF : 8'd0;
            endcase
            mb[i] = (b_mode == 0) ? 8'(i + 1) : 8'd2;
        end
    endtask

    task automatic check_words(input string name, input int mode);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp;
            case (mode)
                0: exp = 32'(i + 1);
                1: exp = 32'hFFFF_FFF8;
                2: exp = 32'(2 * (i + 1));
                default: exp = 32'(-(i + 1));
            endcase
            assert_cnt++;
            if (got[i] !== exp) begin
                fail_cnt++;
                $display("FAIL %s word %0d: got %h required %h", name, i, got[i], exp);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        assert_cnt++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || core_start !== 1'b0 || timeout_err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: s_ready=%b m_valid=%b core_start=%b timeout_err=%b required 0",
                     s_ready, m_valid, core_start, timeout_err);
        end
        assert_cnt++;
        if (a_flat !== '0 || b_flat !== '0 || m_data !== '0 || bridge_busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_data: a=%h b=%h m_data=%h busy=%b required 0", a_flat, b_flat, m_data, bridge_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        assert_cnt++;
        if (s_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL reset_release: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_identity;
        int s0;
        s0 = start_cnt;
        set_ab(0, 0);
        send_range(1'b0, 0, 16, 0);
        send_range(1'b1, 0, 16, 0);
        assert_cnt++;
        if (a_flat[7:0] !== 8'd1 || a_flat[15:8] !== 8'd0 || b_flat[127:120] !== 8'd16) begin
            fail_cnt++;
            $display("FAIL load_layout: a[0]=%h a[1]=%h b[15]=%h required 01/00/10",
                     a_flat[7:0], a_flat[15:8], b_flat[127:120]);
        end
        collect(1'b0);
        check_words("identity", 0);
        assert_cnt++;
        if (start_cnt - s0 !== 1) begin
            fail_cnt++;
            $display("FAIL start_pulses: got %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_gaps;
        set_ab(1, 1);
        send_range(1'b0, 0, 16, 3);
        send_range(1'b1, 0, 16, 3);
        collect(1'b0);
        check_words("neg_gaps", 1);
    endtask

    task automatic test_backpressure;
        set_ab(0, 0);
        send_range(1'b0, 0, 16, 0);
        send_range(1'b1, 0, 16, 0);
        collect(1'b1);
        check_words("backpressure", 0);
    endtask

    task automatic test_reset_midload;
        for (int i = 0; i < 16; i++) ma[i] = 8'h55;
        send_range(1'b0, 0, 10, 0);
        rst_n = 1'b0;
        #1;
        assert_cnt++;
        if (a_flat !== '0 || s_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL midload_reset: a=%h s_ready=%b required 0/0", a_flat, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_ab(2, 0);
        send_range(1'b0, 0, 16, 0);
        send_range(1'b1, 0, 16, 0);
        collect(1'b0);
        check_words("reload", 2);
    endtask

    task automatic test_done_ignore;
        int s0;
        s0 = start_cnt;
        set_ab(3, 0);
        send_range(1'b0, 0, 16, 0);
        send_range(1'b1, 0, 5, 0);
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        assert_cnt++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || bridge_busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL done_in_load_b: s_ready=%b m_valid=%b busy=%b required 1/0/1",
                     s_ready, m_valid, bridge_busy);
        end
        send_range(1'b1, 5, 16, 0);
        collect(1'b0);
        check_words("done_ignore", 3);
        assert_cnt++;
        if (start_cnt - s0 !== 1) begin
            fail_cnt++;
            $display("FAIL done_ignore_start: got %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_timeout;
        int n;
        logic saw_valid;
        core_en = 1'b0;
        set_ab(0, 0);
        send_range(1'b0, 0, 16, 0);
        send_range(1'b1, 0, 16, 0);
        n = 0;
        while (!core_start && n < 20) begin @(negedge clk); n++; end
        assert_cnt++;
        if (core_start !== 1'b1) begin
            fail_cnt++;
            $display("FAIL timeout_start: core_start=%b required 1", core_start);
        end
        saw_valid = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (m_valid) saw_valid = 1'b1;
        end
        assert_cnt++;
        if (timeout_err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL timeout_early: timeout_err=%b required 0 at cycle 15", timeout_err);
        end
        @(negedge clk);
        if (m_valid) saw_valid = 1'b1;
        assert_cnt++;
        if (timeout_err !== 1'b1 || s_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL timeout_flag: timeout_err=%b s_ready=%b required 1/1", timeout_err, s_ready);
        end
        assert_cnt++;
        if (saw_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL timeout_no_output: m_valid seen=%b required 0", saw_valid);
        end
        repeat (3) @(negedge clk);
        assert_cnt++;
        if (timeout_err !== 1'b1) begin
            fail_cnt++;
            $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
        end
        core_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        core_en = 1'b1; done_force = 1'b0;
        test_reset;
        test_identity;
        test_gaps;
        test_backpressure;
        test_reset_midload;
        test_done_ignore;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
